// File: rtl/pc_gen_if.sv
// Fetch-side bundle of the program counter generator: control requests in,
// fetch address, exception PC and status out.
interface pc_gen_if #(
    parameter int XLEN = 32
);
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            trap_req;
    logic            halt_req;
    logic            resume;
    logic            fetch_ready;
    logic            fetch_valid;
    logic [XLEN-1:0] PC_out;
    logic [XLEN-1:0] PC_plus;
    logic            misalign_err;
    logic [XLEN-1:0] epc_out;
    logic            halted;

    modport slave (
        input  redirect_valid,
        input  redirect_pc,
        input  trap_req,
        input  halt_req,
        input  resume,
        input  fetch_ready,
        output fetch_valid,
        output PC_out,
        output PC_plus,
        output misalign_err,
        output epc_out,
        output halted
    );

    modport master (
        output redirect_valid,
        output redirect_pc,
        output trap_req,
        output halt_req,
        output resume,
        output fetch_ready,
        input  fetch_valid,
        input  PC_out,
        input  PC_plus,
        input  misalign_err,
        input  epc_out,
        input  halted
    );
endinterface

// File: rtl/pc_gen.sv
// Program counter generator: BOOT/RUN/HALT sequencer choosing the next fetch
// address from trap, redirect, accepted-fetch increment or stall hold.
module pc_gen #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
    parameter int              INC          = 4
) (
    input logic     clk,
    input logic     reset,
    pc_gen_if.slave bus
);
    localparam logic [XLEN-1:0] INC_W      = XLEN'(INC);
    // INC is a power of two, so INC-1 masks exactly the bits that must be zero
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INC - 1);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_HALT
    } state_t;

    state_t          state_reg;
    logic [XLEN-1:0] pc_reg;
    logic [XLEN-1:0] epc_reg;
    logic            fetch_valid_reg;
    logic            halted_reg;
    logic            misalign_err_reg;
    logic [XLEN-1:0] pc_plus;
    logic            redirect_misaligned;

    assign pc_plus             = pc_reg + INC_W;
    assign redirect_misaligned = |(bus.redirect_pc & ALIGN_MASK);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg        <= ST_BOOT;
            pc_reg           <= RESET_VECTOR;
            epc_reg          <= '0;
            fetch_valid_reg  <= 1'b0;
            halted_reg       <= 1'b0;
            misalign_err_reg <= 1'b0;
        end else begin
            misalign_err_reg <= 1'b0;
            case (state_reg)
                ST_BOOT: begin
                    state_reg       <= ST_RUN;
                    fetch_valid_reg <= 1'b1;
                    halted_reg      <= 1'b0;
                end

                ST_RUN: begin
                    if (bus.trap_req) begin
                        // Trap beats halt: the FSM stays in RUN
                        pc_reg  <= TRAP_VECTOR;
                        epc_reg <= pc_reg;
                    end else begin
                        if (bus.redirect_valid) begin
                            if (redirect_misaligned) begin
                                pc_reg           <= TRAP_VECTOR;
                                epc_reg          <= bus.redirect_pc;
                                misalign_err_reg <= 1'b1;
                            end else begin
                                pc_reg <= bus.redirect_pc;
                            end
                        end else if (bus.fetch_ready) begin
                            pc_reg <= pc_plus;
                        end
                        if (bus.halt_req) begin
                            state_reg       <= ST_HALT;
                            fetch_valid_reg <= 1'b0;
                            halted_reg      <= 1'b1;
                        end
                    end
                end

                ST_HALT: begin
                    // Redirects and fetch acceptance are ignored while halted
                    if (bus.trap_req) begin
                        state_reg       <= ST_RUN;
                        pc_reg          <= TRAP_VECTOR;
                        epc_reg         <= pc_reg;
                        fetch_valid_reg <= 1'b1;
                        halted_reg      <= 1'b0;
                    end else if (bus.resume) begin
                        state_reg       <= ST_RUN;
                        fetch_valid_reg <= 1'b1;
                        halted_reg      <= 1'b0;
                    end
                end

                default: begin
                    state_reg       <= ST_BOOT;
                    fetch_valid_reg <= 1'b0;
                    halted_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.fetch_valid  = fetch_valid_reg;
    assign bus.PC_out       = pc_reg;
    assign bus.PC_plus      = pc_plus;
    assign bus.misalign_err = misalign_err_reg;
    assign bus.epc_out      = epc_reg;
    assign bus.halted       = halted_reg;
endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: vector table replayed through a scoreboard,
// plus hand-written asynchronous reset sequences.
module tb_pc_gen;
    logic clk;
    logic reset;

    pc_gen_if #(.XLEN(32)) bus ();

    pc_gen #(
        .XLEN        (32),
        .RESET_VECTOR(32'h0),
        .TRAP_VECTOR (32'h0000_0100),
        .INC         (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        trap;
        logic        redir;
        logic [31:0] rpc;
        logic        halt;
        logic        resume;
        logic        fr;
        logic [31:0] pc;
        logic [31:0] epc;
        logic        fv;
        logic        hlt;
        logic        mis;
    } vec_t;

    vec_t vecs[$];
    vec_t sb_q[$];
    int   n_cmp;
    int   n_bad;
    int   n_txn;

    function automatic vec_t mk(logic trap, logic redir, logic [31:0] rpc, logic halt,
                                logic resume, logic fr, logic [31:0] pc, logic [31:0] epc,
                                logic fv, logic hlt, logic mis);
        vec_t v;
        v.trap = trap; v.redir = redir; v.rpc = rpc; v.halt = halt; v.resume = resume;
        v.fr = fr; v.pc = pc; v.epc = epc; v.fv = fv; v.hlt = hlt; v.mis = mis;
        return v;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.trap_req       = v.trap;
        bus.redirect_valid = v.redir;
        bus.redirect_pc    = v.rpc;
        bus.halt_req       = v.halt;
        bus.resume         = v.resume;
        bus.fetch_ready    = v.fr;
    endtask

    task automatic check_outputs(input string tag, input vec_t e);
        logic [31:0] plus_exp;
        plus_exp = e.pc + 32'd4;
        cmp({tag, ".PC_out"}, bus.PC_out, e.pc);
        cmp({tag, ".PC_plus"}, bus.PC_plus, plus_exp);
        cmp({tag, ".epc_out"}, bus.epc_out, e.epc);
        cmp({tag, ".fetch_valid"}, 32'(bus.fetch_valid), 32'(e.fv));
        cmp({tag, ".halted"}, 32'(bus.halted), 32'(e.hlt));
        cmp({tag, ".misalign_err"}, 32'(bus.misalign_err), 32'(e.mis));
    endtask

    // Called at a negedge: drive, push expectation, compare after the next posedge
    task automatic step(input string tag, input vec_t v);
        vec_t e;
        drive(v);
        sb_q.push_back(v);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_outputs(tag, e);
        $display("txn %0d %s: pc=%08h epc=%08h fv=%0b halted=%0b mis=%0b",
                 n_txn, tag, bus.PC_out, bus.epc_out, bus.fetch_valid, bus.halted,
                 bus.misalign_err);
        n_txn++;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t idle;
        vec_t rst_e;
        n_cmp = 0;
        n_bad = 0;
        n_txn = 0;
        idle  = mk(0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0);
        rst_e = mk(0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0);

        //          trap redir rpc           halt res fr  pc            epc           fv hlt mis
        vecs.push_back(mk(0, 0, 32'h0,         0, 0, 1, 32'h0,         32'h0,  1, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,         0, 0, 1, 32'h4,         32'h0,  1, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,         0, 0, 1, 32'h8,         32'h0,  1, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,         0, 0, 0, 32'h8,         32'h0,  1, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,         0, 0, 0, 32'h8,         32'h0,  1, 0, 0));
        vecs.push_back(mk(0, 1, 32'h40,        0, 0, 0, 32'h40,        32'h0,  1, 0, 0));
        vecs.push_back(mk(0, 1, 32'h10,        0, 0, 1, 32'h10,        32'h0,  1, 0, 0));
        vecs.push_back(mk(0, 1, 32'h42,        0, 0, 1, 32'h100,       32'h42, 1, 0, 1));
        vecs.push_back(mk(0, 0, 32'h0,         0, 0, 0, 32'h100,       32'h42, 1, 0, 0));
        vecs.push_back(mk(0, 1, 32'h20,        0, 0, 0, 32'h20,        32'h42, 1, 0, 0));
        vecs.push_back(mk(1, 1, 32'h80,        1, 0, 1, 32'h100,       32'h20, 1, 0, 0));
        vecs.push_back(mk(0, 1, 32'hC,         0, 0, 0, 32'hC,         32'h20, 1, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,         1, 0, 1, 32'h10,        32'h20, 0, 1, 0));
        vecs.push_back(mk(0, 1, 32'h80,        0, 0, 1, 32'h10,        32'h20, 0, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,         0, 0, 1, 32'h10,        32'h20, 0, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,         0, 1, 1, 32'h10,        32'h20, 1, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,         0, 0, 1, 32'h14,        32'h20, 1, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,         1, 0, 0, 32'h14,        32'h20, 0, 1, 0));
        vecs.push_back(mk(1, 0, 32'h0,         0, 0, 0, 32'h100,       32'h14, 1, 0, 0));
        vecs.push_back(mk(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 32'hFFFF_FFFC, 32'h14, 1, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,         0, 0, 1, 32'h0,         32'h14, 1, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,         0, 0, 1, 32'h4,         32'h14, 1, 0, 0));
        vecs.push_back(mk(1, 0, 32'h0,         0, 0, 0, 32'h100,       32'h4,  1, 0, 0));
        vecs.push_back(mk(1, 1, 32'h42,        0, 0, 1, 32'h100,       32'h100, 1, 0, 0));
        vecs.push_back(mk(0, 1, 32'h200,       1, 0, 1, 32'h200,       32'h100, 0, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,         0, 1, 0, 32'h200,       32'h100, 1, 0, 0));
        vecs.push_back(mk(0, 1, 32'h201,       0, 0, 1, 32'h100,       32'h201, 1, 0, 1));

        // Reset state, then release at a negedge so the next posedge is the BOOT edge
        reset = 1'b0;
        drive(idle);
        #2;
        check_outputs("reset", rst_e);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_outputs("boot", rst_e);

        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("vec%0d", i), vecs[i]);
        end

        // Asynchronous reset mid-cycle, right after a misalign pulse
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_outputs("async_rst_run", rst_e);
        @(negedge clk);
        // Reset held across an edge with trap/redirect/halt asserted
        step("rst_hold", mk(1, 1, 32'h80, 1, 0, 1, 32'h0, 32'h0, 0, 0, 0));
        reset = 1'b1;
        step("rst_boot", mk(0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 1, 0, 0));
        step("rst_stall", mk(0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 1, 0, 0));
        step("rst_inc", mk(0, 0, 32'h0, 0, 0, 1, 32'h4, 32'h0, 1, 0, 0));
        step("rst_halt", mk(0, 0, 32'h0, 1, 0, 1, 32'h8, 32'h0, 0, 1, 0));
        // Asynchronous reset while halted
        #3;
        reset = 1'b0;
        #1;
        check_outputs("async_rst_halt", rst_e);
        @(negedge clk);
        reset = 1'b1;
        step("halt_boot", mk(0, 0, 32'h0, 0, 0, 1, 32'h0, 32'h0, 1, 0, 0));
        step("halt_inc", mk(0, 0, 32'h0, 0, 0, 1, 32'h4, 32'h0, 1, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
